// File: rtl/mult_div_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit producing HI/LO for MULT, MULTU, DIV, DIVU.
// Signed operations run on operand magnitudes and fix the sign up when the result is written.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     m_q;
  logic [2*WIDTH-1:0]   p_q;
  logic [2*WIDTH-1:0]   p_d;
  logic                 neg_hi_q;
  logic                 neg_lo_q;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_sh;
  logic [WIDTH:0]       div_df;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
    mag = (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  // Multiply: negate the whole product. Divide: remainder follows the dividend,
  // quotient follows the XOR of the operand signs.
  function automatic logic [2*WIDTH-1:0] fixup(input logic [2*WIDTH-1:0] p,
                                               input logic is_div,
                                               input logic neg_hi,
                                               input logic neg_lo);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    r = p[2*WIDTH-1:WIDTH];
    q = p[WIDTH-1:0];
    if (!is_div) begin
      fixup = neg_lo ? -p : p;
    end else begin
      if (neg_hi) r = -r;
      if (neg_lo) q = -q;
      fixup = {r, q};
    end
  endfunction

  // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
    div_sh  = p_q[2*WIDTH-1:WIDTH-1];
    div_df  = div_sh - {1'b0, m_q};
    p_d     = p_q;
    if (op_q[1]) begin
      if (!div_df[WIDTH]) p_d = {div_df[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
      else                p_d = {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
    end else begin
      p_d = {mul_sum, p_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q     <= op;
            cnt_q    <= '0;
            div_zero <= 1'b0;
            m_q      <= mag(b, !op[0]);
            p_q      <= {{WIDTH{1'b0}}, mag(a, !op[0])};
            neg_lo_q <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi_q <= !op[0] && a[WIDTH-1];
            if (op[1] && (b == '0)) begin
              state_q  <= S_DONE;
              div_zero <= 1'b1;
              done     <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            {hi, lo} <= fixup(p_d, op_q[1], neg_hi_q, neg_lo_q);
            state_q  <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector tables, hand-written reset/start sequences,
// and random operations checked against an arithmetic reference model (WIDTH=32 and 8).
module tb_mult_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start32, busy32, done32, dz32;
  logic        start8, busy8, done8, dz8;
  logic [1:0]  op32, op8;
  logic [31:0] a32, b32, hi32, lo32;
  logic [7:0]  a8, b8, hi8, lo8;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] mhi[2];
  logic [63:0] mlo[2];

  mult_div_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_zero(dz32));

  mult_div_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8));

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] ehi;
    logic [63:0] elo;
    logic        ez;
    int          pulse;
  } vec_t;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [1:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (w == 8) begin
      start8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = st; op32 = op; a32 = a[31:0]; b32 = b[31:0];
    end
  endtask

  task automatic sample(input int w, output logic bz, output logic dn, output logic dz,
                        output logic [63:0] h, output logic [63:0] l);
    if (w == 8) begin
      bz = busy8; dn = done8; dz = dz8; h = 64'(hi8); l = 64'(lo8);
    end else begin
      bz = busy32; dn = done32; dz = dz32; h = 64'(hi32); l = 64'(lo32);
    end
  endtask

  // Reference: full-width products and truncating division on plain integers.
  task automatic model(input int w, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] phi, input logic [63:0] plo,
                       output logic [63:0] hi, output logic [63:0] lo, output logic z);
    logic [63:0] mask, ua, ub, p;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    hi = phi; lo = plo; z = 1'b0;
    case (op)
      2'd0: begin p = sa * sb; hi = (p >> w) & mask; lo = p & mask; end
      2'd1: begin p = ua * ub; hi = (p >> w) & mask; lo = p & mask; end
      2'd2: begin
        if (ub == 64'd0) z = 1'b1;
        else begin q = sa / sb; r = sa % sb; hi = r & mask; lo = q & mask; end
      end
      default: begin
        if (ub == 64'd0) z = 1'b1;
        else begin hi = ua % ub; lo = ua / ub; end
      end
    endcase
  endtask

  task automatic run(input int w, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] ehi, input logic [63:0] elo, input logic ez,
                     input int pulse, input string tag);
    int idx, lat;
    bit busy_ok, hold_ok;
    logic bz, dn, dz;
    logic [63:0] h, l;
    idx = (w == 8) ? 1 : 0;
    lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    @(negedge clk);
    drive(w, 1'b1, op, a, b);
    @(posedge clk);
    #1 drive(w, 1'b0, 2'($urandom), rnd64(), rnd64());
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      sample(w, bz, dn, dz, h, l);
      if (c == 1) chk({tag, " div_zero@cycle1"}, 64'(dz), 64'(ez));
      if (dn) begin
        lat = c;
        chk({tag, " busy@done"}, 64'(bz), 64'd0);
      end else begin
        if (!bz) busy_ok = 1'b0;
        if (h !== mhi[idx] || l !== mlo[idx]) hold_ok = 1'b0;
      end
      drive(w, 1'(c == pulse), 2'($urandom), rnd64(), rnd64());
      if (dn) break;
    end
    chk({tag, " latency"}, 64'(lat), ez ? 64'd1 : 64'(w + 1));
    chk({tag, " busy-run"}, 64'(busy_ok), 64'd1);
    chk({tag, " hilo-held"}, 64'(hold_ok), 64'd1);
    chk({tag, " hi"}, h, ehi);
    chk({tag, " lo"}, l, elo);
    chk({tag, " div_zero"}, 64'(dz), 64'(ez));
    @(negedge clk);
    drive(w, 1'b0, 2'd0, 64'd0, 64'd0);
    sample(w, bz, dn, dz, h, l);
    chk({tag, " single-done"}, 64'(dn), 64'd0);
    chk({tag, " idle-after"}, 64'(bz), 64'd0);
    mhi[idx] = ehi;
    mlo[idx] = elo;
  endtask

  initial begin
    vec_t t32[$];
    vec_t t8[$];
    logic bz, dn, dz, zz, seen;
    logic [63:0] h, l, ehi, elo, ra, rb;
    logic [1:0] rop;

    reset = 1'b1;
    drive(32, 1'b0, 2'd0, 64'd0, 64'd0);
    drive(8, 1'b0, 2'd0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    for (int w = 8; w <= 32; w += 24) begin
      sample(w, bz, dn, dz, h, l);
      chk($sformatf("reset%0d busy", w), 64'(bz), 64'd0);
      chk($sformatf("reset%0d done", w), 64'(dn), 64'd0);
      chk($sformatf("reset%0d hi", w), h, 64'd0);
      chk($sformatf("reset%0d lo", w), l, 64'd0);
      chk($sformatf("reset%0d div_zero", w), 64'(dz), 64'd0);
    end
    mhi[0] = 64'd0; mlo[0] = 64'd0; mhi[1] = 64'd0; mlo[1] = 64'd0;
    reset = 1'b0;

    t32.push_back('{2'd0, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFFF, 64'hFFFFFFEB, 1'b0, 0});
    t32.push_back('{2'd1, 64'hFFFFFFFF, 64'h2,        64'h1,        64'hFFFFFFFE, 1'b0, 0});
    t32.push_back('{2'd2, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 64'hFFFFFFFD, 1'b0, 0});
    t32.push_back('{2'd3, 64'd100,      64'd7,        64'd2,        64'd14,       1'b0, 0});
    t32.push_back('{2'd2, 64'h80000000, 64'hFFFFFFFF, 64'h0,        64'h80000000, 1'b0, 0});
    t32.push_back('{2'd3, 64'd0,        64'd5,        64'd0,        64'd0,        1'b0, 0});
    t32.push_back('{2'd3, 64'h56781234, 64'h10000,    64'h1234,     64'h5678,     1'b0, 0});
    t32.push_back('{2'd3, 64'd100,      64'd0,        64'h1234,     64'h5678,     1'b1, 0});
    t32.push_back('{2'd2, 64'd100,      64'd0,        64'h1234,     64'h5678,     1'b1, 1});
    t32.push_back('{2'd0, 64'd3,        64'd5,        64'd0,        64'd15,       1'b0, 0});
    t32.push_back('{2'd2, 64'hFFFFFF9C, 64'd7,        64'hFFFFFFFE, 64'hFFFFFFF2, 1'b0, 0});
    t32.push_back('{2'd2, 64'd100,      64'hFFFFFFF9, 64'd2,        64'hFFFFFFF2, 1'b0, 0});
    t32.push_back('{2'd0, 64'h80000000, 64'h80000000, 64'h40000000, 64'h0,        1'b0, 0});
    t32.push_back('{2'd0, 64'h80000000, 64'h1,        64'hFFFFFFFF, 64'h80000000, 1'b0, 0});
    t32.push_back('{2'd0, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFFF, 64'hFFFFFFEB, 1'b0, 5});
    t32.push_back('{2'd1, 64'hFFFFFFFF, 64'h2,        64'h1,        64'hFFFFFFFE, 1'b0, 33});
    for (int i = 0; i < t32.size(); i++)
      run(32, t32[i].op, t32[i].a, t32[i].b, t32[i].ehi, t32[i].elo, t32[i].ez, t32[i].pulse,
          $sformatf("t32[%0d]", i));

    t8.push_back('{2'd0, 64'h80, 64'h80, 64'h40, 64'h00, 1'b0, 0});
    t8.push_back('{2'd2, 64'h81, 64'h0A, 64'hF9, 64'hF4, 1'b0, 0});
    t8.push_back('{2'd1, 64'hFF, 64'hFF, 64'hFE, 64'h01, 1'b0, 0});
    t8.push_back('{2'd2, 64'h80, 64'hFF, 64'h00, 64'h80, 1'b0, 0});
    for (int i = 0; i < t8.size(); i++)
      run(8, t8[i].op, t8[i].a, t8[i].b, t8[i].ehi, t8[i].elo, t8[i].ez, t8[i].pulse,
          $sformatf("t8[%0d]", i));

    for (int w = 8; w <= 32; w += 24) begin
      for (int n = 0; n < 120; n++) begin
        rop = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
          0: ra = 64'd1 << (w - 1);
          1: ra = 64'hFFFFFFFF;
          2: ra = 64'd0;
          default: ra = rnd64();
        endcase
        case ($urandom_range(0, 7))
          0: rb = 64'd0;
          1: rb = 64'hFFFFFFFF;
          2: rb = 64'd1;
          default: rb = rnd64();
        endcase
        model(w, rop, ra, rb, mhi[w == 8], mlo[w == 8], ehi, elo, zz);
        run(w, rop, ra, rb, ehi, elo, zz, 0, $sformatf("rand%0d[%0d] op%0d", w, n, rop));
      end
    end

    @(negedge clk);
    drive(32, 1'b1, 2'd0, 64'd7, 64'd3);
    @(posedge clk);
    #1 drive(32, 1'b0, 2'd0, 64'd0, 64'd0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sample(32, bz, dn, dz, h, l);
    chk("midrun-reset busy", 64'(bz), 64'd0);
    chk("midrun-reset done", 64'(dn), 64'd0);
    chk("midrun-reset hi", h, 64'd0);
    chk("midrun-reset lo", l, 64'd0);
    chk("midrun-reset div_zero", 64'(dz), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done32 || busy32) seen = 1'b1;
    end
    chk("midrun-reset no-done", 64'(seen), 64'd0);

    reset = 1'b1;
    drive(32, 1'b1, 2'd1, 64'd5, 64'd5);
    @(negedge clk);
    reset = 1'b0;
    drive(32, 1'b0, 2'd0, 64'd0, 64'd0);
    sample(32, bz, dn, dz, h, l);
    chk("reset+start busy", 64'(bz), 64'd0);
    chk("reset+start done", 64'(dn), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done32 || busy32) seen = 1'b1;
    end
    chk("reset+start ignored", 64'(seen), 64'd0);
    chk("reset+start hi", 64'(hi32), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
